kb_code_fifo: RTL and testbench
===============================

Name: kb_code_fifo

Overview:
- Sits between the PS/2 scan-code receiver and any key consumer, such as the UART hex monitor or a text/VGA console.
- Takes the receiver's per-byte tick and data and decodes the PS/2 set-2 make/break protocol.
- Pushes one entry per released key into a first-word-fall-through FIFO, so each key press yields exactly one code regardless of typematic repeat.
- Each entry is the key code plus an extended-key flag (E0 prefix).

Parameters:
W_SIZE, 2, FIFO address width; depth = 2**W_SIZE entries (default 4).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
scan_tick  in  1  one-cycle strobe: scan_data holds a new received byte
scan_data  in  8  received PS/2 byte, valid only when scan_tick=1
rd_key  in  1  pop request for the head entry
key_code  out  8  head entry key code (FWFT); 0 while key_empty=1
key_ext  out  1  head entry extended flag; 0 while key_empty=1
key_empty  out  1  FIFO holds no entries
key_full  out  1  FIFO holds 2**W_SIZE entries
overflow  out  1  sticky: a push was dropped because the FIFO was full; cleared only by reset

Behaviour:
- Reset (async, immediate):
  - decoder state = S_MAKE, ext_flag = 0
  - read/write pointers = 0, key_empty = 1, key_full = 0, overflow = 0, key_code = 0, key_ext = 0
  - FIFO storage array is not cleared.
- Decoder FSM acts only on cycles with scan_tick=1; all other cycles hold state.
- S_MAKE:
  - byte 0xE0: ext_flag <= 1, stay.
  - byte 0xF0: go to S_BRK, ext_flag unchanged.
  - any other byte (make code or typematic repeat): ext_flag <= 0, stay, no push.
- S_BRK:
  - byte 0xE0: ext_flag <= 1, stay.
  - byte 0xF0: stay, no push (tolerates repeated F0).
  - any other byte c: push {ext_flag, c}, ext_flag <= 0, go to S_MAKE.
- Push timing:
  - The push is written on the clock edge ending the scan_tick cycle.
  - key_empty falls, and key_code/key_ext show the entry, in the next cycle (latency 1).
- Pop rules:
  - rd_key=1 with key_empty=0 advances the read pointer at the clock edge; the next entry (or empty) is visible the following cycle.
  - rd_key with key_empty=1 is ignored; pointers and flags are unchanged.
- Full condition:
  - Push while key_full=1 and no valid pop: entry dropped, overflow <= 1, contents unchanged.
  - Push and pop in the same cycle while full: both take effect; count stays at depth, key_full stays 1, no overflow.
  - Push and pop in the same cycle while non-empty, not full: both take effect, count unchanged.
- Flags:
  - Registered; derived from pointer comparison (separate full/empty registers or an extra pointer bit are both acceptable).
  - Pointers wrap modulo 2**W_SIZE.
- Output masking: key_code and key_ext are forced to 0 whenever key_empty=1.
- Reset mid-sequence: a pending F0 or E0 is discarded; subsequent bytes are decoded from S_MAKE.

Test Plan:
1. Basic key: ticks 0x1C, 0xF0, 0x1C -> key_empty falls one cycle after the last tick; key_code=0x1C, key_ext=0; rd_key pulse -> key_empty=1, key_code=0.
2. Extended key: ticks 0xE0, 0x75, 0xE0, 0xF0, 0x75 -> one entry: key_code=0x75, key_ext=1. Then ticks 0xF0, 0x1C -> second entry 0x1C with key_ext=0.
3. Typematic: ticks 0x1C ×5, 0xF0, 0x1C -> exactly one entry 0x1C; ticks 0xF0, 0xF0, 0x2D -> one entry 0x2D.
4. Overflow (W_SIZE=2):
   - Release sequences for 0x15, 0x1D, 0x24, 0x2D -> key_full=1, overflow=0.
   - Release of 0x2C -> overflow=1, key_full=1.
   - Four pops return 0x15, 0x1D, 0x24, 0x2D in order; key_empty=1 after; overflow stays 1.
5. Simultaneous events:
   - FIFO full; rd_key asserted in the same cycle as the final 0x2C tick of a release -> no overflow, key_full remains 1.
   - Head becomes the second-oldest entry; 0x2C is last out.
   - rd_key on empty FIFO -> no change.
6. Reset mid-operation:
   - Ticks 0xF0, reset pulse, tick 0x1C -> no entry, key_empty=1.
   - Reset asserted with 3 entries queued -> key_empty=1, overflow=0, key_code=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/kb_code_fifo.sv
// PS/2 set-2 make/break decoder feeding a first-word-fall-through key FIFO.
// One entry {ext, code} is queued per key release; typematic repeats are ignored.
module kb_code_fifo #(
    parameter int unsigned W_SIZE = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_tick,
    input  logic [7:0] scan_data,
    input  logic       rd_key,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_empty,
    output logic       key_full,
    output logic       overflow
);

    localparam int unsigned Depth = 2 ** W_SIZE;

    typedef enum logic {StMake, StBrk} state_e;

    state_e            state_q, state_d;
    logic              ext_q, ext_d;
    logic              ovf_q, ovf_d;
    logic [W_SIZE:0]   wr_ptr_q, wr_ptr_d;
    logic [W_SIZE:0]   rd_ptr_q, rd_ptr_d;
    logic [8:0]        mem_q [Depth];
    logic [8:0]        head;
    logic              push_req, push, pop;

    // Decoder: only scan_tick cycles move the state.
    always_comb begin
        state_d  = state_q;
        ext_d    = ext_q;
        push_req = 1'b0;
        if (scan_tick) begin
            unique case (state_q)
                StMake: begin
                    if (scan_data == 8'hE0) begin
                        ext_d = 1'b1;
                    end else if (scan_data == 8'hF0) begin
                        state_d = StBrk;
                    end else begin
                        ext_d = 1'b0;
                    end
                end
                StBrk: begin
                    if (scan_data == 8'hE0) begin
                        ext_d = 1'b1;
                    end else if (scan_data != 8'hF0) begin
                        push_req = 1'b1;
                        ext_d    = 1'b0;
                        state_d  = StMake;
                    end
                end
                default: state_d = StMake;
            endcase
        end
    end

    // Extra MSB on each pointer separates full from empty.
    assign key_empty = (wr_ptr_q == rd_ptr_q);
    assign key_full  = (wr_ptr_q[W_SIZE] != rd_ptr_q[W_SIZE]) &&
                       (wr_ptr_q[W_SIZE-1:0] == rd_ptr_q[W_SIZE-1:0]);

    always_comb begin
        pop      = rd_key & ~key_empty;
        push     = push_req & (~key_full | pop);
        wr_ptr_d = wr_ptr_q + {{W_SIZE{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{W_SIZE{1'b0}}, pop};
        ovf_d    = ovf_q | (push_req & key_full & ~pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StMake;
            ext_q    <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            ext_q    <= ext_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately not reset; the empty mask hides stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[W_SIZE-1:0]] <= {ext_q, scan_data};
        end
    end

    assign head     = mem_q[rd_ptr_q[W_SIZE-1:0]];
    assign key_code = key_empty ? 8'h00 : head[7:0];
    assign key_ext  = key_empty ? 1'b0 : head[8];
    assign overflow = ovf_q;

endmodule

// File: tb/tb_kb_code_fifo.sv
// Directed bench for kb_code_fifo; expected entries are queued as releases are
// driven and compared against the FWFT head as the bench pops them.
module tb_kb_code_fifo;

    localparam int unsigned Depth = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       scan_tick;
    logic [7:0] scan_data;
    logic       rd_key;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_empty;
    logic       key_full;
    logic       overflow;

    int         errors = 0;
    int         checks = 0;
    logic [8:0] sb[$];
    logic       exp_ovf = 1'b0;

    kb_code_fifo #(.W_SIZE(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .scan_tick (scan_tick),
        .scan_data (scan_data),
        .rd_key    (rd_key),
        .key_code  (key_code),
        .key_ext   (key_ext),
        .key_empty (key_empty),
        .key_full  (key_full),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [7:0] b);
        @(negedge clk);
        scan_tick = 1'b1;
        scan_data = b;
        @(negedge clk);
        scan_tick = 1'b0;
        scan_data = 8'h00;
    endtask

    task automatic release_key(input logic [7:0] code, input logic ext);
        if (ext) tick(8'hE0);
        tick(8'hF0);
        if (sb.size() == Depth) exp_ovf = 1'b1;
        else sb.push_back({ext, code});
        tick(code);
    endtask

    // Compare head with the oldest expected entry, then pop it.
    task automatic pop_check(input string tag);
        logic [8:0] exp;
        exp = (sb.size() != 0) ? sb.pop_front() : 9'h1FF;
        chk({tag, "_nonempty"}, {8'h0, key_empty}, 9'h0);
        chk(tag, {key_ext, key_code}, exp);
        rd_key = 1'b1;
        @(negedge clk);
        rd_key = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        exp_ovf = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        scan_tick = 1'b0;
        scan_data = 8'h00;
        rd_key    = 1'b0;
        #2;
        chk("rst_empty", {8'h0, key_empty}, 9'h1);
        chk("rst_full", {8'h0, key_full}, 9'h0);
        chk("rst_ovf", {8'h0, overflow}, 9'h0);
        chk("rst_head", {key_ext, key_code}, 9'h000);
        @(negedge clk);
        reset = 1'b0;

        // Basic key: make, then release.
        tick(8'h1C);
        tick(8'hF0);
        chk("t1_empty_before", {8'h0, key_empty}, 9'h1);
        sb.push_back({1'b0, 8'h1C});
        tick(8'h1C);
        pop_check("t1_head");
        chk("t1_empty_after", {8'h0, key_empty}, 9'h1);
        chk("t1_code_masked", {key_ext, key_code}, 9'h000);

        // Extended key followed by a normal release.
        tick(8'hE0);
        tick(8'h75);
        release_key(8'h75, 1'b1);
        tick(8'hF0);
        sb.push_back({1'b0, 8'h1C});
        tick(8'h1C);
        pop_check("t2_ext");
        pop_check("t2_norm");
        chk("t2_empty", {8'h0, key_empty}, 9'h1);

        // Typematic repeats and doubled F0.
        for (int i = 0; i < 5; i++) tick(8'h1C);
        release_key(8'h1C, 1'b0);
        tick(8'hF0);
        release_key(8'h2D, 1'b0);
        pop_check("t3_rep");
        pop_check("t3_dblf0");
        chk("t3_empty", {8'h0, key_empty}, 9'h1);

        // Fill, then overflow.
        release_key(8'h15, 1'b0);
        release_key(8'h1D, 1'b0);
        release_key(8'h24, 1'b0);
        release_key(8'h2D, 1'b0);
        chk("t4_full", {8'h0, key_full}, 9'h1);
        chk("t4_no_ovf", {8'h0, overflow}, {8'h0, exp_ovf});
        release_key(8'h2C, 1'b0);
        chk("t4_ovf", {8'h0, overflow}, {8'h0, exp_ovf});
        chk("t4_still_full", {8'h0, key_full}, 9'h1);
        for (int i = 0; i < 4; i++) pop_check("t4_drain");
        chk("t4_empty", {8'h0, key_empty}, 9'h1);
        chk("t4_ovf_sticky", {8'h0, overflow}, 9'h1);

        // Push and pop together while full.
        do_reset();
        release_key(8'h15, 1'b0);
        release_key(8'h1D, 1'b0);
        release_key(8'h24, 1'b0);
        release_key(8'h2D, 1'b0);
        tick(8'hF0);
        chk("t5_head_old", {key_ext, key_code}, sb.pop_front());
        sb.push_back({1'b0, 8'h2C});
        scan_tick = 1'b1;
        scan_data = 8'h2C;
        rd_key    = 1'b1;
        @(negedge clk);
        scan_tick = 1'b0;
        rd_key    = 1'b0;
        chk("t5_no_ovf", {8'h0, overflow}, 9'h0);
        chk("t5_full", {8'h0, key_full}, 9'h1);
        for (int i = 0; i < 4; i++) pop_check("t5_drain");
        rd_key = 1'b1;
        @(negedge clk);
        rd_key = 1'b0;
        chk("t5_rd_empty", {8'h0, key_empty}, 9'h1);
        chk("t5_rd_empty_full", {8'h0, key_full}, 9'h0);
        release_key(8'h4A, 1'b0);
        pop_check("t5_after_empty_rd");

        // Reset discards a pending F0.
        tick(8'hF0);
        do_reset();
        tick(8'h1C);
        chk("t6_no_entry", {8'h0, key_empty}, 9'h1);

        // Asynchronous reset with entries queued.
        release_key(8'h15, 1'b0);
        release_key(8'h1D, 1'b1);
        release_key(8'h24, 1'b0);
        chk("t6_queued", {8'h0, key_empty}, 9'h0);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_async_empty", {8'h0, key_empty}, 9'h1);
        chk("t6_async_head", {key_ext, key_code}, 9'h000);
        chk("t6_async_ovf", {8'h0, overflow}, 9'h0);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
